// File: rtl/decode_arbiter_pkg.sv
// Shared handshake encodings, requester IDs and data width for the
// decoder-side pipeline stages.
package decode_arbiter_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } hs_state_t;

  localparam logic REQ0   = 1'b0;
  localparam logic REQ1   = 1'b1;
  localparam int   DATA_W = 32;

  // Width of a counter that must reach the value n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/decode_arbiter_rr_pick2.sv
// Two-way round-robin pick: on a tie the requester that did not win
// last time is chosen.
module rr_pick2
  import decode_arbiter_pkg::*;
(
  input  logic [1:0] i_elig,
  input  logic       i_last_grant,
  output logic       o_valid,
  output logic       o_winner
);

  always_comb begin
    o_valid  = |i_elig;
    o_winner = REQ0;
    if (&i_elig)
      o_winner = ~i_last_grant;
    else if (i_elig[1])
      o_winner = REQ1;
  end

endmodule

// File: rtl/decode_arbiter.sv
// Shares one decoder stage between two producers over the DIR/DOR/ack
// handshake, with an ack watchdog and a completed-transfer counter.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | no word held, picking the next requester
// WAIT_ACK | word held on o_dec_data with o_dec_dor high
module decode_arbiter
  import decode_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_dir,
  input  logic [DATA_W-1:0] i_req0_data,
  input  logic              i_req1_dir,
  input  logic [DATA_W-1:0] i_req1_data,
  output logic              o_req0_ack,
  output logic              o_req1_ack,
  output logic              o_dec_dor,
  output logic [DATA_W-1:0] o_dec_data,
  input  logic              i_dec_ack,
  output logic              o_grant_id,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic [CNT_W-1:0]  o_xfer_count
);

  localparam int                WDOG_W  = cnt_width(TIMEOUT);
  localparam logic [WDOG_W-1:0] WD_LAST = WDOG_W'(TIMEOUT - 1);

  hs_state_t         r_state;
  logic [DATA_W-1:0] r_dec_data;
  logic              r_dec_dor;
  logic              r_req0_ack;
  logic              r_req1_ack;
  logic              r_grant_id;
  logic              r_last_grant;
  logic              r_timeout_err;
  logic [1:0]        r_mask;
  logic [WDOG_W-1:0] r_wdog;
  logic [CNT_W-1:0]  r_xfer_count;

  logic [1:0]        w_elig;
  logic              w_valid;
  logic              w_winner;

  // A just-acked producer may still show its old dir for one cycle.
  assign w_elig = {i_req1_dir, i_req0_dir} & ~r_mask;

  rr_pick2 u_pick (
    .i_elig       (w_elig),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_dec_data    <= '0;
      r_dec_dor     <= 1'b0;
      r_req0_ack    <= 1'b0;
      r_req1_ack    <= 1'b0;
      r_grant_id    <= REQ0;
      r_last_grant  <= REQ1;
      r_timeout_err <= 1'b0;
      r_mask        <= 2'b00;
      r_wdog        <= '0;
      r_xfer_count  <= '0;
    end else begin
      r_req0_ack    <= 1'b0;
      r_req1_ack    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_mask        <= {r_req1_ack, r_req0_ack};
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_dec_data <= (w_winner == REQ1) ? i_req1_data : i_req0_data;
            r_dec_dor  <= 1'b1;
            r_req0_ack <= (w_winner == REQ0);
            r_req1_ack <= (w_winner == REQ1);
            r_grant_id <= w_winner;
            r_wdog     <= '0;
            r_state    <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (i_dec_ack) begin
            r_dec_dor    <= 1'b0;
            r_last_grant <= r_grant_id;
            r_xfer_count <= r_xfer_count + 1'b1;
            r_state      <= ST_IDLE;
          end else if (TIMEOUT != 0 && r_wdog == WD_LAST) begin
            r_dec_dor     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_last_grant  <= r_grant_id;
            r_state       <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_req0_ack    = r_req0_ack;
  assign o_req1_ack    = r_req1_ack;
  assign o_dec_dor     = r_dec_dor;
  assign o_dec_data    = r_dec_data;
  assign o_grant_id    = r_grant_id;
  assign o_busy        = (r_state == ST_WAIT_ACK);
  assign o_timeout_err = r_timeout_err;
  assign o_xfer_count  = r_xfer_count;

endmodule

// File: tb/tb_decode_arbiter.sv
// Directed bench for decode_arbiter: cycle table plus hand sequences for
// stall, watchdog, reset mid-transfer and stale-dir masking.
module tb_decode_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dir0, dir1, dack;
  logic [31:0] d0, d1;

  logic        ack0, ack1, dor, grant, busy, terr;
  logic [31:0] data;
  logic [15:0] xfer;

  logic        w_ack0, w_ack1, w_dor, w_grant, w_busy, w_terr;
  logic [31:0] w_data;
  logic [15:0] w_xfer;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_arbiter #(.TIMEOUT(255), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_req0_dir(dir0), .i_req0_data(d0),
    .i_req1_dir(dir1), .i_req1_data(d1),
    .o_req0_ack(ack0), .o_req1_ack(ack1),
    .o_dec_dor(dor), .o_dec_data(data), .i_dec_ack(dack),
    .o_grant_id(grant), .o_busy(busy),
    .o_timeout_err(terr), .o_xfer_count(xfer)
  );

  decode_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut_wd (
    .i_clk(clk), .i_reset(rst_n),
    .i_req0_dir(dir0), .i_req0_data(d0),
    .i_req1_dir(dir1), .i_req1_data(d1),
    .o_req0_ack(w_ack0), .o_req1_ack(w_ack1),
    .o_dec_dor(w_dor), .o_dec_data(w_data), .i_dec_ack(dack),
    .o_grant_id(w_grant), .o_busy(w_busy),
    .o_timeout_err(w_terr), .o_xfer_count(w_xfer)
  );

  typedef struct {
    logic        rst_n, dir0, dir1;
    logic [31:0] d0, d1;
    logic        dack;
    logic        e_ack0, e_ack1, e_dor;
    logic [31:0] e_data;
    logic        e_grant, e_busy;
    logic [15:0] e_xfer;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic r, logic a, logic b, logic [31:0] x0,
                              logic [31:0] x1, logic k, logic ea0, logic ea1,
                              logic edor, logic [31:0] edat, logic eg,
                              logic eb, logic [15:0] ex);
    vec_t v;
    v.rst_n = r; v.dir0 = a; v.dir1 = b; v.d0 = x0; v.d1 = x1; v.dack = k;
    v.e_ack0 = ea0; v.e_ack1 = ea1; v.e_dor = edor; v.e_data = edat;
    v.e_grant = eg; v.e_busy = eb; v.e_xfer = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic a, input logic b,
                       input logic [31:0] x0, input logic [31:0] x1,
                       input logic k);
    rst_n = r; dir0 = a; dir1 = b; d0 = x0; d1 = x1; dack = k;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    step();
  endtask

  int n_dor, n_terr, n_ack0;

  initial begin
    drive(0, 0, 0, 0, 0, 0);

    // rst dir0 dir1 d0 d1 dack | ack0 ack1 dor data grant busy xfer
    vt[0]  = mk(0,0,0,32'h0,32'h0,0,          0,0,0,32'h0,0,0,0);
    vt[1]  = mk(1,1,0,32'h10,32'h0,0,         1,0,1,32'h10,0,1,0);
    vt[2]  = mk(1,0,0,32'h10,32'h0,0,         0,0,1,32'h10,0,1,0);
    vt[3]  = mk(1,0,0,32'h0,32'h0,0,          0,0,1,32'h10,0,1,0);
    vt[4]  = mk(1,0,0,32'h0,32'h0,1,          0,0,0,32'h10,0,0,1);
    vt[5]  = mk(1,0,0,32'h0,32'h0,0,          0,0,0,32'h10,0,0,1);
    vt[6]  = mk(0,0,0,32'h0,32'h0,0,          0,0,0,32'h0,0,0,0);
    vt[7]  = mk(1,1,1,32'hA000_0000,32'hB000_0000,0, 1,0,1,32'hA000_0000,0,1,0);
    vt[8]  = mk(1,1,1,32'hA000_0001,32'hB000_0000,1, 0,0,0,32'hA000_0000,0,0,1);
    vt[9]  = mk(1,1,1,32'hA000_0001,32'hB000_0000,0, 0,1,1,32'hB000_0000,1,1,1);
    vt[10] = mk(1,1,1,32'hA000_0001,32'hB000_0001,1, 0,0,0,32'hB000_0000,1,0,2);
    vt[11] = mk(1,1,1,32'hA000_0001,32'hB000_0001,0, 1,0,1,32'hA000_0001,0,1,2);
    vt[12] = mk(1,1,1,32'hA000_0002,32'hB000_0001,1, 0,0,0,32'hA000_0001,0,0,3);
    vt[13] = mk(1,1,1,32'hA000_0002,32'hB000_0001,0, 0,1,1,32'hB000_0001,1,1,3);
    vt[14] = mk(1,1,1,32'hA000_0002,32'hB000_0002,1, 0,0,0,32'hB000_0001,1,0,4);
    vt[15] = mk(1,0,0,32'hA000_0002,32'hB000_0002,0, 0,0,0,32'hB000_0001,1,0,4);
    vt[16] = mk(1,0,0,32'h0,32'h0,1,          0,0,0,32'hB000_0001,1,0,4);

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst_n, vt[i].dir0, vt[i].dir1, vt[i].d0, vt[i].d1, vt[i].dack);
      step();
      chk($sformatf("row%0d ack0", i), {31'b0, ack0}, {31'b0, vt[i].e_ack0});
      chk($sformatf("row%0d ack1", i), {31'b0, ack1}, {31'b0, vt[i].e_ack1});
      chk($sformatf("row%0d dor", i), {31'b0, dor}, {31'b0, vt[i].e_dor});
      chk($sformatf("row%0d data", i), data, vt[i].e_data);
      chk($sformatf("row%0d grant", i), {31'b0, grant}, {31'b0, vt[i].e_grant});
      chk($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, vt[i].e_busy});
      chk($sformatf("row%0d terr", i), {31'b0, terr}, 32'h0);
      chk($sformatf("row%0d xfer", i), {16'b0, xfer}, {16'b0, vt[i].e_xfer});
    end

    // Stall: long ack wait, requests from the other side ignored.
    do_reset();
    drive(1, 1, 0, 32'h55, 32'h66, 0);
    step();
    chk("stall accept", data, 32'h55);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 32'h0, 32'h66, 0);
      step();
      chk("stall data", data, 32'h55);
      chk("stall busy", {31'b0, busy}, 32'h1);
      chk("stall ack1", {31'b0, ack1}, 32'h0);
      chk("stall terr", {31'b0, terr}, 32'h0);
    end
    drive(1, 0, 0, 0, 0, 1);
    step();
    chk("stall release xfer", {16'b0, xfer}, 32'h1);
    chk("stall release dor", {31'b0, dor}, 32'h0);

    // Watchdog expiry on the TIMEOUT=4 instance.
    do_reset();
    drive(1, 1, 0, 32'h77, 0, 0);
    step();
    n_dor = w_dor ? 1 : 0;
    n_terr = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
      if (w_dor) n_dor++;
      if (w_terr) n_terr++;
    end
    chk("wd dor cycles", n_dor, 4);
    chk("wd terr pulses", n_terr, 1);
    chk("wd xfer unchanged", {16'b0, w_xfer}, 32'h0);

    // Ack on the expiry cycle counts as success.
    drive(1, 1, 0, 32'h78, 0, 0);
    step();
    chk("wd2 accept dor", {31'b0, w_dor}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
      chk("wd2 hold dor", {31'b0, w_dor}, 32'h1);
    end
    drive(1, 0, 0, 0, 0, 1);
    step();
    chk("wd2 dor", {31'b0, w_dor}, 32'h0);
    chk("wd2 terr", {31'b0, w_terr}, 32'h0);
    chk("wd2 xfer", {16'b0, w_xfer}, 32'h1);
    drive(1, 0, 0, 0, 0, 0);
    step();
    chk("wd2 terr after", {31'b0, w_terr}, 32'h0);

    // Reset in the middle of a transfer.
    do_reset();
    drive(1, 0, 1, 0, 32'h1234, 0);
    step();
    drive(1, 0, 0, 0, 0, 1);
    step();
    drive(1, 1, 0, 32'hDEAD_BEEF, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    step();
    chk("mid data", data, 32'hDEAD_BEEF);
    chk("mid xfer", {16'b0, xfer}, 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rst dor", {31'b0, dor}, 32'h0);
    chk("rst data", data, 32'h0);
    chk("rst busy", {31'b0, busy}, 32'h0);
    chk("rst grant", {31'b0, grant}, 32'h0);
    chk("rst acks", {30'b0, ack1, ack0}, 32'h0);
    chk("rst terr", {31'b0, terr}, 32'h0);
    chk("rst xfer", {16'b0, xfer}, 32'h0);
    drive(1, 1, 1, 32'hC0, 32'hC1, 0);
    step();
    chk("post rst ack0", {31'b0, ack0}, 32'h1);
    chk("post rst grant", {31'b0, grant}, 32'h0);
    chk("post rst data", data, 32'hC0);

    // Stale dir held one cycle past the ack must not be re-accepted.
    do_reset();
    n_ack0 = 0;
    drive(1, 1, 0, 32'h99, 0, 0);
    step();
    if (ack0) n_ack0++;
    drive(1, 1, 0, 32'h99, 0, 1);
    step();
    if (ack0) n_ack0++;
    chk("stale released dor", {31'b0, dor}, 32'h0);
    drive(1, 1, 0, 32'h99, 0, 0);
    step();
    if (ack0) n_ack0++;
    chk("stale masked dor", {31'b0, dor}, 32'h0);
    chk("stale masked busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      step();
      if (ack0) n_ack0++;
    end
    chk("stale ack0 pulses", n_ack0, 1);
    chk("stale xfer", {16'b0, xfer}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
